// File: rtl/div32_seq.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU; optional early-out via DIV32_EARLY_OUT_EN.
// Latency: 34 cycles from the i_start edge to o_done (2 cycles for special operands with early-out).
// Backpressure: none; the pipeline stalls on o_busy, i_start outside IDLE is ignored, i_flush aborts.
module div32_seq #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] b_abs;
    logic [XLEN-1:0] a_raw;
    logic [XLEN-1:0] res_fix;
    logic            op_rem;
    logic            q_neg;
    logic            r_neg;
    logic            div0;
    logic            ovf;

    logic            accept;
    logic            is_signed;
    logic            det_div0;
    logic            det_ovf;
    logic [XLEN-1:0] a_abs_in;
    logic [XLEN-1:0] b_abs_in;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic            ge;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_fin;

    assign accept    = (state == S_IDLE) && i_start && !i_flush;
    assign is_signed = ~i_op[0];
    assign det_div0  = (i_b == '0);
    assign det_ovf   = is_signed && (i_a == MIN_NEG) && (i_b == ALL_ONES);
    assign a_abs_in  = (is_signed && i_a[XLEN-1]) ? -i_a : i_a;
    assign b_abs_in  = (is_signed && i_b[XLEN-1]) ? -i_b : i_b;

    // The partial remainder is always below the divisor, so the shifted value is
    // below 2*b and the 33-bit difference never wraps; its MSB is a valid sign.
    assign rem_sh = {rem, quo[XLEN-1]};
    assign diff   = rem_sh - {1'b0, b_abs};
    assign ge     = ~diff[XLEN];

    always_comb begin
        q_fin = q_neg ? -quo : quo;
        r_fin = r_neg ? -rem : rem;
        if (div0) begin
            q_fin = ALL_ONES;
            r_fin = a_raw;
        end else if (ovf) begin
            q_fin = MIN_NEG;
            r_fin = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef DIV32_EARLY_OUT_EN
                    state_nxt = (det_div0 || det_ovf) ? S_FIX : S_CALC;
`else
                    state_nxt = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (cnt == '0) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (i_flush) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_result <= '0;
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            b_abs    <= '0;
            a_raw    <= '0;
            res_fix  <= '0;
            op_rem   <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div0     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            // Busy and done lag the state by one edge so every output is registered.
            o_busy <= (state != S_IDLE) && !i_flush;
            o_done <= (state == S_DONE) && !i_flush;
            if ((state == S_DONE) && !i_flush) begin
                o_result <= res_fix;
            end

            if (accept) begin
                op_rem <= i_op[1];
                a_raw  <= i_a;
                b_abs  <= b_abs_in;
                quo    <= a_abs_in;
                rem    <= '0;
                cnt    <= CW'(XLEN - 1);
                q_neg  <= is_signed && (i_a[XLEN-1] ^ i_b[XLEN-1]);
                r_neg  <= is_signed && i_a[XLEN-1];
                div0   <= det_div0;
                ovf    <= det_ovf;
            end else if ((state == S_CALC) && !i_flush) begin
                quo <= {quo[XLEN-2:0], ge};
                rem <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
                cnt <= cnt - 1'b1;
            end else if ((state == S_FIX) && !i_flush) begin
                res_fix <= op_rem ? r_fin : q_fin;
            end
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq: vector table, flush/ignored-start, async reset and back-to-back sequences.
module tb_div32_seq;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_flush;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div32_seq #(.XLEN(32)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_flush  (i_flush),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_edge();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic special;
        special = (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV32_EARLY_OUT_EN
        return special ? 2 : 34;
`else
        return special ? 34 : 34;
`endif
    endfunction

    // Called #1 after an edge; the next edge is edge 0. Returns at #1 after the o_done edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        i_op    = op;
        i_a     = a;
        i_b     = b;
        i_start = 1'b1;
        wait_edge();
        i_start = 1'b0;
        lat = -1;
        res = 32'h0;
        for (int k = 1; k <= 60; k++) begin
            wait_edge();
            if (k == 1) chk("busy_after_edge1", {31'b0, o_busy}, 32'd1);
            if (o_done) begin
                lat = k;
                res = o_result;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] old_res;
        int          lat;
        int          done_seen;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2};
        vecs[3]  = '{OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE};
        vecs[4]  = '{OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2};
        vecs[5]  = '{OP_DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2};
        vecs[6]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[7]  = '{OP_REMU, 32'd5,          32'd0,          32'd5};
        vecs[8]  = '{OP_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF};
        vecs[9]  = '{OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
        vecs[10] = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[11] = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0};
        vecs[12] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0};
        vecs[13] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[14] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
        vecs[15] = '{OP_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000};
        vecs[16] = '{OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3};
        vecs[17] = '{OP_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF};

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_flush = 1'b0;
        i_op    = 2'b00;
        i_a     = 32'h0;
        i_b     = 32'h0;
        repeat (3) wait_edge();
        chk("reset_busy",   {31'b0, o_busy}, 32'd0);
        chk("reset_done",   {31'b0, o_done}, 32'd0);
        chk("reset_result", o_result,        32'd0);
        i_rst_n = 1'b1;
        repeat (2) wait_edge();

        // Table: each op starts on the edge right after the previous o_done (back-to-back).
        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, exp_latency(vecs[i].op, vecs[i].a, vecs[i].b));
        end

        // Done is a single pulse; result holds and busy drops afterwards.
        old_res = o_result;
        wait_edge();
        chk("done_pulse_len", {31'b0, o_done}, 32'd0);
        chk("busy_after_done", {31'b0, o_busy}, 32'd0);
        chk("result_held", o_result, 32'hFFFF_FFFF);

        // Flush at edge 10 of DIVU 1000/3.
        i_op = OP_DIVU; i_a = 32'd1000; i_b = 32'd3; i_start = 1'b1;
        wait_edge();
        i_start = 1'b0;
        repeat (9) wait_edge();
        i_flush = 1'b1;
        wait_edge();
        i_flush = 1'b0;
        chk("flush_busy", {31'b0, o_busy}, 32'd0);
        chk("flush_done", {31'b0, o_done}, 32'd0);
        chk("flush_result_kept", o_result, old_res);

        // New start at edge 11 with 9/2; a start pulse during CALC must be ignored.
        i_op = OP_DIVU; i_a = 32'd9; i_b = 32'd2; i_start = 1'b1;
        wait_edge();
        i_start = 1'b0;
        lat = -1;
        done_seen = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 5) begin
                i_op = OP_REMU; i_a = 32'd100; i_b = 32'd7; i_start = 1'b1;
            end
            wait_edge();
            i_start = 1'b0;
            if (o_done) begin
                lat = k;
                break;
            end
        end
        chk("after_flush_result", o_result, 32'd4);
        chk("after_flush_latency", lat, 32'd34);

        // Async reset mid-CALC.
        i_op = OP_DIVU; i_a = 32'd1000; i_b = 32'd3; i_start = 1'b1;
        wait_edge();
        i_start = 1'b0;
        repeat (10) wait_edge();
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_busy",   {31'b0, o_busy}, 32'd0);
        chk("arst_done",   {31'b0, o_done}, 32'd0);
        chk("arst_result", o_result,        32'd0);
        wait_edge();
        i_rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wait_edge();
            if (o_done) done_seen++;
        end
        chk("arst_no_done", done_seen, 32'd0);

        run_op(OP_DIVU, 32'd9, 32'd2, res, lat);
        chk("post_reset_result", res, 32'd4);
        chk("post_reset_latency", lat, 32'd34);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
